// File: rtl/win_checker.sv
// win_checker: sequential Connect-4 game-over detector scanning every 4-cell window of a board snapshot
module win_checker #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int CELL_W  = 3,
  parameter int WIN_LEN = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [CELL_W-1:0][ROWS-1:0][COLS-1:0] board,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  juego_terminado,
  output logic [1:0]                            winner,
  output logic                                  draw,
  output logic [2:0]                            win_row,
  output logic [2:0]                            win_col,
  output logic [1:0]                            win_dir
);
  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
  state_t state, state_n;
  logic [CELL_W-1:0] snap [ROWS][COLS];
  logic [CELL_W-1:0] w [WIN_LEN];
  logic [2:0] r, c;
  logic [1:0] d;
  logic valid, same, match, last, full, accept;
  int ri, ci, dr, dc, rr, cc;
  always_comb begin
    ri = int'(r);
    ci = int'(c);
    dr = (d == 2'd0) ? 0 : 1;
    dc = (d == 2'd1) ? 0 : (d == 2'd3) ? -1 : 1;
    valid = (d[0] || ci <= COLS - WIN_LEN) && (d == 2'd0 || ri <= ROWS - WIN_LEN) &&
            (d != 2'd3 || ci >= WIN_LEN - 1);
    same = 1'b1;
    rr = 0;
    cc = 0;
    for (int i = 0; i < WIN_LEN; i++) begin
      rr = ri + i * dr;
      cc = ci + i * dc;
      w[i] = valid ? snap[rr[2:0]][cc[2:0]] : '0;
      same = same & (w[i] == w[0]);
    end
    match = valid && same && (w[0] == CELL_W'(1) || w[0] == CELL_W'(2));
    last = r == 3'(ROWS - 1) && c == 3'(COLS - 1) && d == 2'd3;
    full = 1'b1;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        full = full & (snap[i][j] == CELL_W'(1) || snap[i][j] == CELL_W'(2));
    accept = state == IDLE && start && !juego_terminado;
    state_n = (state == IDLE) ? (accept ? SCAN : IDLE) :
              (state == SCAN) ? ((match || last) ? FIN : SCAN) : IDLE;
    busy = state == SCAN;
    done = state == FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      d <= '0;
      winner <= '0;
      draw <= 1'b0;
      juego_terminado <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      win_dir <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          snap[i][j] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        r <= '0;
        c <= '0;
        d <= '0;
        winner <= '0;
        draw <= 1'b0;
        win_row <= '0;
        win_col <= '0;
        win_dir <= '0;
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++)
            for (int b = 0; b < CELL_W; b++)
              snap[i][j][b] <= board[b][i][j];
      end else if (state == SCAN) begin
        // scan order: direction fastest, then column, then row
        if (match) begin
          winner <= w[0][1:0];
          win_row <= r;
          win_col <= c;
          win_dir <= d;
          juego_terminado <= 1'b1;
        end else if (last) begin
          draw <= full;
          juego_terminado <= full;
        end else begin
          d <= d + 2'd1;
          if (d == 2'd3) begin
            c <= (c == 3'(COLS - 1)) ? 3'd0 : c + 3'd1;
            if (c == 3'(COLS - 1)) r <= r + 3'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_win_checker.sv
// tb_win_checker: directed and randomized boards checked against a window-walking reference model
module tb_win_checker;
  localparam int ROWS = 6, COLS = 7, CELL_W = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CELL_W-1:0][ROWS-1:0][COLS-1:0] board = '0;
  logic busy, done, juego_terminado, draw;
  logic [1:0] winner, win_dir;
  logic [2:0] win_row, win_col;
  int m [ROWS][COLS];
  int checks = 0, passed = 0;
  int mk, mw, mr, mc, md, mdraw;

  win_checker dut (
    .clk(clk), .rst(rst), .start(start), .board(board), .busy(busy), .done(done),
    .juego_terminado(juego_terminado), .winner(winner), .draw(draw),
    .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic push_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int b = 0; b < CELL_W; b++)
          board[b][r][c] = m[r][c][b];
  endtask

  task automatic clear_m();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r][c] = 0;
  endtask

  task automatic rand_fill(input int p);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int u;
        u = int'($urandom_range(0, 99));
        m[r][c] = (u < p) ? int'($urandom_range(1, 2)) : (u % 3 == 0) ? int'($urandom_range(3, 7)) : 0;
      end
  endtask

  // walk windows in scan order; a window exists when its far end lies on the board
  function automatic void model();
    int full;
    mk = -1; mw = 0; mr = 0; mc = 0; md = 0;
    for (int k = 0; k < ROWS * COLS * 4 && mk < 0; k++) begin
      int r, c, d, dr, dc, er, ec, ok;
      r = k / (COLS * 4);
      c = (k / 4) % COLS;
      d = k % 4;
      dr = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : (d == 3) ? -1 : 1;
      er = r + 3 * dr;
      ec = c + 3 * dc;
      if (er < ROWS && ec >= 0 && ec < COLS && (m[r][c] == 1 || m[r][c] == 2)) begin
        ok = 1;
        for (int i = 1; i < 4; i++)
          if (m[r + i * dr][c + i * dc] != m[r][c]) ok = 0;
        if (ok == 1) begin
          mk = k; mw = m[r][c]; mr = r; mc = c; md = d;
        end
      end
    end
    full = 1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m[r][c] != 1 && m[r][c] != 2) full = 0;
    mdraw = (mk < 0 && full == 1) ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // start at cycle T; inj>0 overwrites the board and pulses start at cycle T+inj
  task automatic run_scan(input string tag, input int inj);
    int n, busy_n, off, term;
    model();
    push_board();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_n = 0;
    while (!done && n < 400) begin
      if (busy) busy_n++;
      if (n == inj) begin
        start = 1'b1;
        for (int r = 0; r < 4; r++) begin
          board[0][r][6] = 1'b1;
          board[1][r][6] = 1'b0;
          board[2][r][6] = 1'b0;
        end
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    off = (mk >= 0) ? mk + 2 : 169;
    term = (mk >= 0 || mdraw == 1) ? 1 : 0;
    check({tag, "_done_cycle"}, n, off);
    check({tag, "_busy_cycles"}, busy_n, off - 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_winner"}, winner, mw);
    check({tag, "_row"}, win_row, mr);
    check({tag, "_col"}, win_col, mc);
    check({tag, "_dir"}, win_dir, md);
    check({tag, "_draw"}, draw, mdraw);
    check({tag, "_terminado"}, juego_terminado, term);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_winner_hold"}, winner, mw);
  endtask

  initial begin
    int bad, n;
    for (int t = 0; t < 2; t++) begin
      start = 1'($urandom_range(0, 1));
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          for (int b = 0; b < CELL_W; b++)
            board[b][r][c] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_winner", winner, 0);
    check("rst_draw", draw, 0);
    check("rst_terminado", juego_terminado, 0);
    check("rst_line", {win_row, win_col, win_dir}, 0);
    rst = 1'b0;
    start = 1'b0;

    do_reset();
    clear_m();
    for (int c = 0; c < 4; c++) m[5][c] = 1;
    run_scan("p1_bottom_row", 0);

    do_reset();
    clear_m();
    for (int i = 0; i < 4; i++) m[i][3 - i] = 2;
    run_scan("p2_anti_diag", 0);

    do_reset();
    clear_m();
    run_scan("empty", 0);

    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r][c] = ((c / 2 + r) % 2) + 1;
    run_scan("full_draw", 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (200) begin
      if (busy || done) bad++;
      @(negedge clk);
    end
    check("draw_start_ignored", bad, 0);
    check("draw_sticky", {juego_terminado, draw}, 2'b11);

    do_reset();
    clear_m();
    run_scan("midscan_frozen", 5);

    do_reset();
    clear_m();
    push_board();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      if (done) bad++;
      @(negedge clk);
    end
    check("rst_mid_no_done", bad, 0);

    for (int t = 0; t < 10; t++) begin
      do_reset();
      rand_fill((t == 9) ? 100 : int'($urandom_range(15, 70)));
      run_scan($sformatf("rand%0d", t), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
